// File: rtl/uart_tx_8n1_if.sv
// Byte-request handshake between a byte source and the UART transmitter.
// The source drives tx_start/tx_data; the transmitter reports tx_busy/tx_done.
interface uart_tx_8n1_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx_8n1.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity,
// STOP_BITS stop bits. baud_en is a one-cycle enable from the divider, not a clock.
module uart_tx_8n1 #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          baud_en,
    uart_tx_8n1_if.slave  bus,
    output logic          tx
);
    localparam int CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
    localparam logic ODD_INV   = (PARITY_ODD != 0);
    localparam logic LAST_STOP = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        IDLE,
        PEND,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    logic [DATA_BITS-1:0] shift;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 stop_cnt;
    logic                 parity_bit;
    logic                 busy_q;
    logic                 done_q;

    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the values from before this edge, independent of order.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            shift      <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            parity_bit <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    // Acceptance never consumes a tick, so PEND always waits
                    // for the next one and the start bit is a full period.
                    if (bus.tx_start) begin
                        shift      <= bus.tx_data;
                        bit_cnt    <= '0;
                        stop_cnt   <= 1'b0;
                        parity_bit <= (^bus.tx_data) ^ ODD_INV;
                        busy_q     <= 1'b1;
                        state      <= PEND;
                    end
                end
                PEND: begin
                    if (baud_en) begin
                        tx    <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (baud_en) begin
                        tx    <= shift[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (baud_en) begin
                        shift   <= {1'b0, shift[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            if (PARITY_EN != 0) begin
                                tx    <= parity_bit;
                                state <= PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            tx <= shift[1];
                        end
                    end
                end
                PARITY: begin
                    if (baud_en) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (baud_en) begin
                        if (stop_cnt == LAST_STOP) begin
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            stop_cnt <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx     <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule
